spike_aer_encoder: RTL

- Sits directly downstream of the SNN core's output spike vector (the same vector driven to monitor_spikes).
- Converts each cycle's parallel spike vector into serialized address-event (AER) records, each carrying the neuron index and a timestamp.
- Buffers records in a small FIFO and presents them on a valid/ready stream for the SPI readout or a host logger.
- Counts lost events when the buffer cannot keep up.

---
 rtl/aer_pkg.sv | 31 +++
 rtl/aer_event_fifo.sv | 57 +++++
 rtl/spike_aer_encoder.sv | 107 ++++++++++
 3 files changed

// File: rtl/aer_pkg.sv
// Shared types and helpers for the spike address-event encoder.
package aer_pkg;

  // Upper bound on spike-vector width handled by the priority encoder.
  localparam int unsigned MaxNeurons = 64;

  // Address field width for a given neuron count (at least one bit).
  function automatic int unsigned addr_width(input int unsigned num_neurons);
    return (num_neurons > 1) ? $clog2(num_neurons) : 1;
  endfunction

  // Field widths of the default configuration.
  localparam int unsigned AddrWidth = addr_width(4);
  localparam int unsigned TsWidth   = 16;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic [TsWidth-1:0]   ts;
  } aer_event_t;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic int unsigned lowest_set_index(input logic [MaxNeurons-1:0] vec);
    int unsigned idx;
    idx = 0;
    for (int i = MaxNeurons - 1; i >= 0; i--) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/aer_event_fifo.sv
// Show-ahead synchronous FIFO; head data reads as zero while empty.
module aer_event_fifo #(
  parameter int unsigned Width = 18,
  parameter int unsigned Depth = 8,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  // Push is refused when full even if a pop happens in the same cycle.
  always_comb begin
    full_o  = (count_q == CntW'(Depth));
    empty_o = (count_q == '0);
    push_ok = push_i & ~full_o;
    pop_ok  = pop_i & ~empty_o;
    wptr_d  = push_ok ? wptr_q + PtrW'(1) : wptr_q;
    rptr_d  = pop_ok ? rptr_q + PtrW'(1) : rptr_q;
    count_d = count_q;
    if (push_ok && !pop_ok) count_d = count_q + CntW'(1);
    else if (!push_ok && pop_ok) count_d = count_q - CntW'(1);
    rdata_o = empty_o ? '0 : mem_q[rptr_q];
    count_o = count_q;
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; contents are masked while empty.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/spike_aer_encoder.sv
// Serialises parallel spike vectors into timestamped address events.
module spike_aer_encoder
  import aer_pkg::*;
#(
  parameter int unsigned NUM_NEURONS = 4,
  parameter int unsigned TS_WIDTH    = 16,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned DROP_WIDTH  = 16,
  localparam int unsigned AddrW      = addr_width(NUM_NEURONS),
  localparam int unsigned CntW       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [NUM_NEURONS-1:0] spikes_in,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [AddrW-1:0]       evt_addr,
  output logic [TS_WIDTH-1:0]    evt_ts,
  output logic [CntW-1:0]        fifo_count,
  output logic                   overflow,
  input  logic                   clear_overflow,
  output logic [DROP_WIDTH-1:0]  drop_count
);

  typedef struct packed {
    logic [AddrW-1:0]    addr;
    logic [TS_WIDTH-1:0] ts;
  } event_t;

  logic [TS_WIDTH-1:0]    ts_q, ts_d, pend_ts_q, pend_ts_d;
  logic [NUM_NEURONS-1:0] pend_q, pend_d, pend_rest;
  logic                   overflow_q, overflow_d;
  logic [DROP_WIDTH-1:0]  drop_count_q, drop_count_d, drop_base;
  logic [MaxNeurons-1:0]  scan_vec;
  logic                   fifo_full, fifo_empty, push, free, drop;
  event_t                 wr_evt, rd_evt;

  // Scanner push, capture/drop decision and next-state of all local state.
  always_comb begin
    scan_vec                  = '0;
    scan_vec[NUM_NEURONS-1:0] = pend_q;
    wr_evt.addr = AddrW'(lowest_set_index(scan_vec));
    wr_evt.ts   = pend_ts_q;
    push        = (pend_q != '0) && !fifo_full;
    // Clearing the lowest set bit: empty afterwards means PEND was one-hot.
    pend_rest   = pend_q & (pend_q - NUM_NEURONS'(1));
    free        = (pend_q == '0) || (push && (pend_rest == '0));
    drop        = enable && (spikes_in != '0) && !free;

    ts_d      = enable ? ts_q + TS_WIDTH'(1) : ts_q;
    pend_d    = push ? pend_rest : pend_q;
    pend_ts_d = pend_ts_q;
    if (enable && (spikes_in != '0) && free) begin
      pend_d    = spikes_in;
      pend_ts_d = ts_q;
    end

    // A drop in the clearing cycle still registers as the first drop.
    drop_base    = clear_overflow ? '0 : drop_count_q;
    drop_count_d = drop_base;
    if (drop && !(&drop_base)) drop_count_d = drop_base + DROP_WIDTH'(1);
    overflow_d = drop ? 1'b1 : (clear_overflow ? 1'b0 : overflow_q);
  end

  // Timestamp, capture register and drop bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q         <= '0;
      pend_q       <= '0;
      pend_ts_q    <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      ts_q         <= ts_d;
      pend_q       <= pend_d;
      pend_ts_q    <= pend_ts_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  aer_event_fifo #(
    .Width ($bits(event_t)),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .wdata_i (wr_evt),
    .pop_i   (evt_ready),
    .rdata_o (rd_evt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Stream outputs straight from the FIFO head.
  always_comb begin
    evt_valid  = !fifo_empty;
    evt_addr   = rd_evt.addr;
    evt_ts     = rd_evt.ts;
    overflow   = overflow_q;
    drop_count = drop_count_q;
  end

endmodule
